adder_tree_accum_ctrl: RTL and testbench
========================================

// Module: adder_tree_accum_ctrl
// PURPOSE
//  Sequences the 8-lane, 20-bit adder-tree reduction so it can sum a multi-beat job.
//  - Accepts LANES x IN_W operand beats over a valid/ready handshake.
//  - Registers each beat onto the tree operand bus and accumulates the returned 23-bit tree sum.
//  - Presents one ACC_W result per job on a valid/ready output.
//  - Sits between the systolic-array column outputs and the result writeback.
// PARAMETERS
//  LANES  8   operand lanes per beat (tree width)
//  IN_W   20  bits per lane operand
//  SUM_W  23  tree result width; must be at least IN_W+clog2(LANES)
//  ACC_W  31  accumulator/result width (SUM_W+8, holds 255 beats without overflow)
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            synchronous, active-high reset
//  start      in   1            begin a job; sampled only in IDLE, or in HOLD with out_ready=1
//  num_beats  in   8            beats in job, latched on start; 0 is treated as 1
//  in_valid   in   1            operand beat valid
//  in_ready   out  1            operand beat accepted when in_valid&in_ready
//  in_data    in   LANES*IN_W   operand beat, lane i at [IN_W*(i+1)-1:IN_W*i]
//  tree_opnd  out  LANES*IN_W   registered operands driven to the adder tree
//  tree_sum   in   SUM_W        combinational tree result for tree_opnd
//  out_valid  out  1            job result valid
//  out_ready  in   1            consumer accepts result
//  out_data   out  ACC_W        job result: sum of all lanes over all beats
//  busy       out  1            state != IDLE
// BEHAVIOUR
//  Reset:
//   - state=IDLE; in_ready, out_valid and busy = 0.
//   - out_data, tree_opnd, accumulator, beat counter and opnd_vld = 0.
//  FSM states:
//   - IDLE:
//     - in_ready=0.
//     - start -> RUN: acc<=0, cnt<=0, nb<=max(num_beats,1).
//   - RUN:
//     - in_ready=1 while cnt<nb.
//     - Each handshake: tree_opnd<=in_data, opnd_vld<=1, cnt<=cnt+1.
//     - Without a handshake: opnd_vld<=0 and tree_opnd holds its value.
//     - opnd_vld=1 each cycle: acc <= acc + zero-extended tree_sum (unsigned, modulo 2^ACC_W).
//     - When cnt==nb and opnd_vld=1: fold in the final sum, out_data<=acc+tree_sum, out_valid<=1, go to HOLD.
//   - HOLD:
//     - in_ready=0; out_valid and out_data held stable until out_ready=1.
//     - On out_valid&out_ready: out_valid<=0; next state is RUN if start=1 that cycle (new job latched as in IDLE), else IDLE.
//  Other rules:
//   - start is ignored in RUN, and in HOLD without out_ready.
//   - Latency: last beat accepted at cycle t -> out_valid=1 at t+2.
//   - Input bubbles (in_valid=0) are allowed anywhere in a job and do not change the result.
//   - Throughput: one beat per cycle. Back-to-back jobs lose 1 cycle in HOLD.
//   - rst mid-job: in-flight beats and the partial sum are discarded; all registers return to reset values next cycle.
//   - in_valid in IDLE/HOLD: not accepted (in_ready=0); data is ignored.
// TESTING
//  1. num_beats=1, all lanes 1 -> out_data=8; out_valid exactly 2 cycles after the accept.
//  2. num_beats=4, all lanes 0xFFFFF, in_valid=1 continuously -> out_data=0x1FFFFE0; in_ready low after 4th beat.
//  3. num_beats=0, one beat of lanes 0..7 (values 0..7) -> treated as 1 beat; out_data=28.
//  4. num_beats=255, all lanes 0xFFFFF -> out_data=2139093000 with no wrap.
//     Then random bubbles on in_valid -> same result.
//  5. out_ready=0 for 5 cycles -> out_data/out_valid stable, in_ready=0, start ignored.
//     Then out_ready=1 with start=1 -> next job begins; busy never drops.
//  6. rst pulsed after 2 of 4 beats -> all outputs 0 next cycle.
//     A new job of 1 beat of lanes 2 -> out_data=16, with no stale contribution.

Source files
------------

// File: rtl/adder_tree_accum_ctrl.sv
// adder_tree_accum_ctrl: sequences multi-beat jobs through the 8-lane adder tree.
// Operand beats are registered onto tree_opnd, the returned tree sum is folded into
// an accumulator one cycle later, and one result per job is held on a valid/ready port.
module adder_tree_accum_ctrl #(
  parameter int unsigned LANES = 8,
  parameter int unsigned IN_W  = 20,
  parameter int unsigned SUM_W = 23,
  parameter int unsigned ACC_W = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            num_beats,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IN_W-1:0] in_data,
  output logic [LANES*IN_W-1:0] tree_opnd,
  input  logic [SUM_W-1:0]      tree_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic                  busy
);

  localparam int unsigned DATA_W = LANES * IN_W;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CMP_W  = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nb;
  logic [ACC_W-1:0] acc;
  logic             opnd_vld;

  logic             accept_c;
  logic [ACC_W-1:0] acc_sum_c;
  logic [CNT_W-1:0] nb_req_c;
  logic             more_after_c;

  // Handshake, running sum and job-length helpers
  assign accept_c     = in_valid & in_ready;
  assign acc_sum_c    = acc + ACC_W'(tree_sum);
  assign nb_req_c     = (num_beats == '0) ? CNT_W'(1) : num_beats;
  assign more_after_c = (CMP_W'(cnt) + CMP_W'(1)) < CMP_W'(nb);

  // Operand register: captures accepted beats; holds its value across bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      tree_opnd <= '0;
      opnd_vld  <= 1'b0;
    end else begin
      opnd_vld <= accept_c;
      if (accept_c) begin
        tree_opnd <= DATA_W'(in_data);
      end
    end
  end

  // Job FSM with beat counter, accumulator and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      nb        <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            acc      <= '0;
            cnt      <= '0;
            nb       <= nb_req_c;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end

        S_RUN: begin
          // count accepted beats; drop in_ready once the last one is taken
          if (accept_c) begin
            cnt      <= cnt + CNT_W'(1);
            in_ready <= more_after_c;
          end
          // fold the tree result of the previous cycle's beat
          if (opnd_vld) begin
            acc <= acc_sum_c;
            if (cnt == nb) begin
              out_data  <= acc_sum_c;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              state    <= S_RUN;
              acc      <= '0;
              cnt      <= '0;
              nb       <= nb_req_c;
              in_ready <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_tree_accum_ctrl.sv
// tb_adder_tree_accum_ctrl: randomized jobs checked against a lane-sum reference model.
module tb_adder_tree_accum_ctrl;

  localparam int unsigned LANES  = 8;
  localparam int unsigned IN_W   = 20;
  localparam int unsigned SUM_W  = 23;
  localparam int unsigned ACC_W  = 31;
  localparam int unsigned DATA_W = LANES * IN_W;
  localparam longint ACC_MASK    = (64'sd1 <<< ACC_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        num_beats;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] tree_opnd;
  logic [SUM_W-1:0]  tree_sum;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              busy;

  int     errors = 0;
  int     checks = 0;
  longint last_exp = 0;

  adder_tree_accum_ctrl #(
    .LANES(LANES), .IN_W(IN_W), .SUM_W(SUM_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_beats(num_beats),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tree_opnd(tree_opnd), .tree_sum(tree_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // sum of all lanes of one beat, plain arithmetic
  function automatic longint beat_sum(input logic [DATA_W-1:0] d);
    longint s = 0;
    for (int i = 0; i < LANES; i++) s += longint'(d[i*IN_W +: IN_W]);
    return s;
  endfunction

  // combinational adder-tree stand-in
  always_comb tree_sum = SUM_W'(beat_sum(tree_opnd));

  // mode 0: random lanes, 1: every lane = val, 2: lane i = i
  function automatic logic [DATA_W-1:0] gen_beat(input int mode, input int val);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < LANES; i++) begin
      case (mode)
        0:       d[i*IN_W +: IN_W] = IN_W'($urandom);
        1:       d[i*IN_W +: IN_W] = IN_W'(val);
        default: d[i*IN_W +: IN_W] = IN_W'(i);
      endcase
    end
    return d;
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // at a negedge: pulse start for one cycle
  task automatic issue_start(input int nb);
    start     = 1'b1;
    num_beats = 8'(nb);
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", longint'(busy), 1);
    chk("start_in_ready", longint'(in_ready), 1);
    chk("start_out_valid", longint'(out_valid), 0);
  endtask

  // feed eff beats with random bubbles, then check latency and result
  task automatic feed(input int eff, input int mode, input int val, input int bubble,
                      input bit keep_valid, output longint exp);
    int sent = 0;
    int cycles = 0;
    exp = 0;
    while (sent < eff && cycles < eff * 20 + 100) begin
      chk("run_in_ready", longint'(in_ready), 1);
      in_valid = ($urandom_range(0, 99) >= bubble);
      in_data  = gen_beat(mode, val);
      if (in_valid) begin
        exp += beat_sum(in_data);
        sent++;
      end
      @(negedge clk);
      cycles++;
    end
    if (sent < eff) chk("feed_timeout", sent, eff);
    exp = exp & ACC_MASK;
    if (keep_valid) in_data = gen_beat(0, 0);
    else in_valid = 1'b0;
    chk("lat_early_valid", longint'(out_valid), 0);
    chk("in_ready_after_last", longint'(in_ready), 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_out_valid", longint'(out_valid), 1);
    chk("out_data", longint'(out_data), exp);
    last_exp = exp;
  endtask

  // hold result for `hold` cycles (start driven and ignored), then release
  task automatic finish_job(input int hold, input bit start_next, input int nb_next);
    out_ready = 1'b0;
    start     = start_next;
    num_beats = 8'(nb_next);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", longint'(out_valid), 1);
      chk("hold_data", longint'(out_data), last_exp);
      chk("hold_in_ready", longint'(in_ready), 0);
      chk("hold_busy", longint'(busy), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    chk("release_valid", longint'(out_valid), 0);
    chk("release_busy", longint'(busy), longint'(start_next));
    chk("release_in_ready", longint'(in_ready), longint'(start_next));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    longint e;
    int     nbv;
    int     nxt;
    bit     chained;

    rst = 1'b1; start = 1'b0; num_beats = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_opnd_nonzero", longint'(tree_opnd != '0), 0);
    rst = 1'b0;

    // valid data in IDLE is not accepted
    in_valid = 1'b1; in_data = gen_beat(1, 5);
    repeat (2) @(negedge clk);
    chk("idle_in_ready", longint'(in_ready), 0);
    chk("idle_busy", longint'(busy), 0);
    in_valid = 1'b0;

    // single beat of ones
    issue_start(1);
    feed(1, 1, 1, 0, 1'b0, e);
    chk("t1_sum", longint'(out_data), 8);
    finish_job(0, 1'b0, 0);

    // four full-scale beats, in_valid held high
    issue_start(4);
    feed(4, 1, 'hFFFFF, 0, 1'b1, e);
    chk("t2_sum", longint'(out_data), 'h1FFFFE0);
    finish_job(0, 1'b0, 0);

    // num_beats=0 behaves as one beat
    issue_start(0);
    feed(1, 2, 0, 0, 1'b0, e);
    chk("t3_sum", longint'(out_data), 28);
    finish_job(0, 1'b0, 0);

    // maximum job, then same job with bubbles
    issue_start(255);
    feed(255, 1, 'hFFFFF, 0, 1'b0, e);
    chk("t4_sum", longint'(out_data), 2139093000);
    finish_job(0, 1'b0, 0);
    issue_start(255);
    feed(255, 1, 'hFFFFF, 40, 1'b0, e);
    chk("t4_bubble_sum", longint'(out_data), 2139093000);
    finish_job(0, 1'b0, 0);

    // back-pressure with ignored start, then chained job
    issue_start(3);
    feed(3, 0, 0, 20, 1'b0, e);
    finish_job(5, 1'b1, 2);
    feed(2, 0, 0, 0, 1'b0, e);
    finish_job(0, 1'b0, 0);

    // reset mid-job, then a clean job
    issue_start(4);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = gen_beat(1, 'h7777);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", longint'(in_ready), 0);
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_out_data", longint'(out_data), 0);
    chk("mid_rst_opnd_nonzero", longint'(tree_opnd != '0), 0);
    issue_start(1);
    feed(1, 1, 2, 0, 1'b0, e);
    chk("t6_sum", longint'(out_data), 16);
    finish_job(0, 1'b0, 0);

    // randomized jobs, optionally chained through HOLD
    chained = 1'b0;
    nbv = 0;
    for (int j = 0; j < 8; j++) begin
      if (!chained) begin
        nbv = $urandom_range(0, 20);
        issue_start(nbv);
      end
      feed((nbv == 0) ? 1 : nbv, 0, 0, 30, 1'b0, e);
      nxt     = $urandom_range(0, 20);
      chained = (j < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      finish_job($urandom_range(0, 3), chained, nxt);
      nbv = nxt;
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
